// File: rtl/acc_serializer.sv
`default_nettype none
// ============================================================================
// Module      : acc_serializer
// Description : Reads accumulator words from a source SRAM (LANES lanes of
//               DATA_WIDTH bits per word), applies a per-lane output transform
//               (KEEP / ZERO / RELU / ASHR) and streams every lane LSB-first
//               over a ready/enable serial interface. One word is prefetched
//               into a holding register so words stream without gaps.
// Revision    : 1.0 - initial release
// ============================================================================
module acc_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int SRAM_DEPTH = 1024,
    localparam int AW        = $clog2(SRAM_DEPTH),
    localparam int SW        = $clog2(DATA_WIDTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        sram_en,
    output logic [AW-1:0]               sram_addr,
    input  logic [LANES*DATA_WIDTH-1:0] sram_data,
    input  logic                        shift_start,
    output logic                        shift_idle,
    input  logic [1:0]                  shift_ctrl,
    input  logic [SW-1:0]               shift_amt,
    input  logic [AW-1:0]               start_addr,
    input  logic [AW-1:0]               img_size,
    input  logic                        serial_ready,
    output logic [LANES-1:0]            serial_output,
    output logic                        serial_start,
    output logic                        serial_en
);

    localparam int            c_WW       = LANES * DATA_WIDTH;
    localparam logic [1:0]    c_KEEP     = 2'd0;
    localparam logic [1:0]    c_ZERO     = 2'd1;
    localparam logic [1:0]    c_RELU     = 2'd2;
    localparam logic [1:0]    c_ASHR     = 2'd3;
    localparam logic [1:0]    c_IDLE     = 2'd0;
    localparam logic [1:0]    c_FETCH    = 2'd1;
    localparam logic [1:0]    c_STREAM   = 2'd2;
    localparam logic [1:0]    c_DRAIN    = 2'd3;
    localparam logic [SW-1:0] c_LAST_BIT = SW'(DATA_WIDTH - 1);
    localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [1:0]       r_mode;
    logic [SW-1:0]    r_amt;
    logic [AW-1:0]    r_addr;
    logic [AW:0]      r_reads_left;
    logic [AW:0]      r_words_left;
    logic [c_WW-1:0]  r_cur;
    logic             r_cur_vld;
    logic [c_WW-1:0]  r_hold;
    logic             r_hold_vld;
    logic             r_rd_pend;
    logic [SW-1:0]    r_bit;

    logic [c_WW-1:0]  w_in;
    logic [c_WW-1:0]  w_word;
    logic [LANES-1:0] w_bits;
    logic             w_active;
    logic             w_accept;
    logic             w_full;
    logic             w_fetch;
    logic             w_have;
    logic             w_xfer;
    logic             w_word_done;
    logic             w_final;
    logic             w_last_fetch;

    assign w_active = (r_state != c_IDLE);
    assign w_accept = (r_state == c_IDLE) & shift_start;

    // Two of {current word, holding word, read in flight} occupy all storage.
    assign w_full = (r_cur_vld & r_hold_vld) | (r_cur_vld & r_rd_pend) | (r_hold_vld & r_rd_pend);

    // Reads (real or, in ZERO mode, virtual) keep the same cadence in every mode.
    assign w_fetch      = ((r_state == c_FETCH) | (r_state == c_STREAM)) & (r_reads_left != '0) & ~w_full;
    assign w_last_fetch = (r_reads_left == '0) | (w_fetch & (r_reads_left == c_CNT_ONE));

    // A word arriving from SRAM is presented directly while the word register is empty.
    assign w_have      = r_cur_vld | r_rd_pend;
    assign w_word      = r_cur_vld ? r_cur : w_in;
    assign w_xfer      = w_active & w_have & serial_ready;
    assign w_word_done = w_xfer & (r_bit == c_LAST_BIT);
    assign w_final     = w_word_done & (r_words_left == c_CNT_ONE);

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            logic [DATA_WIDTH-1:0] w_raw;
            logic [DATA_WIDTH-1:0] w_lane_in;
            logic [DATA_WIDTH-1:0] w_cur_lane;

            assign w_raw = sram_data[k*DATA_WIDTH +: DATA_WIDTH];

            // Output transform applied as the word is loaded.
            always_comb begin
                w_lane_in = w_raw;
                case (r_mode)
                    c_KEEP:  w_lane_in = w_raw;
                    c_ZERO:  w_lane_in = '0;
                    c_RELU:  w_lane_in = w_raw[DATA_WIDTH-1] ? '0 : w_raw;
                    c_ASHR:  w_lane_in = $signed(w_raw) >>> r_amt;
                    default: w_lane_in = w_raw;
                endcase
            end

            assign w_in[k*DATA_WIDTH +: DATA_WIDTH] = w_lane_in;
            assign w_cur_lane = w_word[k*DATA_WIDTH +: DATA_WIDTH];
            assign w_bits[k]  = w_cur_lane[r_bit];
        end
    endgenerate

    // Next-state logic; completing the final bit returns to IDLE from any state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (shift_start) w_state_nxt = c_FETCH;
            c_FETCH:  if (r_rd_pend) w_state_nxt = w_last_fetch ? c_DRAIN : c_STREAM;
            c_STREAM: if (w_last_fetch) w_state_nxt = c_DRAIN;
            c_DRAIN:  w_state_nxt = c_DRAIN;
            default:  w_state_nxt = c_IDLE;
        endcase
        if (w_final) w_state_nxt = c_IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Transfer configuration, address/count tracking and word storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode       <= c_KEEP;
            r_amt        <= '0;
            r_addr       <= '0;
            r_reads_left <= '0;
            r_words_left <= '0;
            r_cur        <= '0;
            r_cur_vld    <= 1'b0;
            r_hold       <= '0;
            r_hold_vld   <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_bit        <= '0;
        end else if (w_accept) begin
            r_mode       <= shift_ctrl;
            r_amt        <= shift_amt;
            r_addr       <= start_addr;
            r_reads_left <= {1'b0, img_size} + c_CNT_ONE;
            r_words_left <= {1'b0, img_size} + c_CNT_ONE;
            r_cur_vld    <= 1'b0;
            r_hold_vld   <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_bit        <= '0;
        end else begin
            r_rd_pend <= w_fetch;
            if (w_fetch) begin
                r_addr       <= r_addr + AW'(1);
                r_reads_left <= r_reads_left - c_CNT_ONE;
            end
            if (w_xfer) r_bit <= (r_bit == c_LAST_BIT) ? '0 : r_bit + SW'(1);
            if (w_word_done) r_words_left <= r_words_left - c_CNT_ONE;

            if (r_cur_vld) begin
                if (w_word_done) begin
                    if (r_hold_vld) begin
                        r_cur      <= r_hold;
                        r_hold_vld <= r_rd_pend;
                        if (r_rd_pend) r_hold <= w_in;
                    end else if (r_rd_pend) begin
                        r_cur <= w_in;
                    end else begin
                        r_cur_vld <= 1'b0;
                    end
                end else if (r_rd_pend) begin
                    r_hold     <= w_in;
                    r_hold_vld <= 1'b1;
                end
            end else if (r_rd_pend) begin
                r_cur     <= w_in;
                r_cur_vld <= ~w_word_done;
            end
        end
    end

    assign sram_en       = w_fetch & (r_mode != c_ZERO);
    assign sram_addr     = r_addr;
    assign shift_idle    = (r_state == c_IDLE);
    assign serial_en     = w_active & w_have;
    assign serial_start  = serial_en & (r_bit == '0);
    assign serial_output = serial_en ? w_bits : '0;

endmodule
`default_nettype wire
